// File: rtl/ram_sp_bytewr_clr.sv
// Single-port synchronous RAM with byte write enables, a registered read, selectable
// read-during-write, a zero-fill engine that runs after reset and on clr_req, and
// optional per-byte even parity when RAM_PARITY_EN is defined.
module ram_sp_bytewr_clr #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                wena,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                rvalid,
  input  logic                clr_req,
  output logic                busy,
  output logic                par_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_busy;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rvalid;
  logic              r_par_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              w_clear;
  logic              w_acc;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_par_err;

  assign w_clear  = (r_state == S_CLEAR);
  assign w_acc    = (r_state == S_IDLE) && ena;
  assign w_wr     = w_acc && wena;
  assign w_rd_old = r_mem[addr];

  // Next-state and fill-pointer logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  // Old word with the enabled bytes replaced by write data
  always_comb begin
    w_merged = w_rd_old;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_wr && be[i]) begin
        w_merged[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  assign w_rd_word   = (RDW_MODE == 0) ? w_rd_old : w_merged;
  assign w_mem_we    = w_clear || w_wr;
  assign w_mem_addr  = w_clear ? r_ptr : addr;
  assign w_mem_wdata = w_clear ? '0 : w_merged;

  // Storage array is not reset; the fill engine zeroes it
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par_old;
  logic [NB-1:0] w_par_new;
  logic [NB-1:0] w_par_chk;
  logic [NB-1:0] w_par_calc;
  logic [NB-1:0] w_par_wdata;

  assign w_par_old = r_par[addr];

  // Parity bits follow their bytes: only written bytes get a fresh bit
  always_comb begin
    w_par_new = w_par_old;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_wr && be[i]) begin
        w_par_new[i] = ^data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_par_calc = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      w_par_calc[i] = ^w_rd_word[8*i +: 8];
    end
  end

  assign w_par_chk   = (RDW_MODE == 0) ? w_par_old : w_par_new;
  assign w_par_err   = |(w_par_calc ^ w_par_chk);
  assign w_par_wdata = w_clear ? '0 : w_par_new;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_addr] <= w_par_wdata;
    end
  end
`else
  assign w_par_err = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_ptr      <= '0;
      r_busy     <= 1'b1;
      r_data_out <= '0;
      r_rvalid   <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_busy    <= (w_state_nxt == S_CLEAR);
      r_rvalid  <= w_acc;
      r_par_err <= w_acc && w_par_err;
      if (w_acc) begin
        r_data_out <= w_rd_word;
      end
    end
  end

  assign data_out = r_data_out;
  assign rvalid   = r_rvalid;
  assign busy     = r_busy;
  assign par_err  = r_par_err;

endmodule
